cross_bar_slave_ctrl: RTL and testbench

Per-slave transaction controller for the crossbar. It arbitrates round-robin among MASTER_N masters targeting one slave port and forwards one transaction at a time to that slave. It holds ownership for the whole request/acknowledge/response sequence and routes the slave's acknowledge, response and read data back to the owning master. A response watchdog prevents a silent slave from locking the port.

---
 rtl/cross_bar_slave_ctrl.sv | 159 +++++++++++++++
 tb/tb_cross_bar_slave_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/cross_bar_slave_ctrl.sv
// cross_bar_slave_ctrl
// Per-slave transaction controller for the crossbar. Arbitrates round-robin
// among MASTER_N masters targeting one slave port, forwards one transaction at
// a time, and routes acknowledge / response / read data back to the owner.
// A response watchdog returns an error response if the slave stays silent.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   m_req, m_cmd        per-master request and command (1 = write, 0 = read)
//   m_addr, m_wdata     per-master address / write data, master i at [i*W +: W]
//   m_ack, m_resp       one-hot acknowledge / read-response pulses
//   m_err               qualifies m_resp, 1 = timeout error
//   m_rdata             shared read data, valid with m_resp
//   s_req .. s_wdata    request to the slave
//   s_ack, s_resp       slave accept / read response pulse
//   s_rdata             slave read data, valid with s_resp
//   grant_id            index of the current owner
//   busy                high whenever the controller is not IDLE
module cross_bar_slave_ctrl #(
    parameter int MASTER_N = 4,
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int TIMEOUT  = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [MASTER_N-1:0]         m_req,
    input  logic [MASTER_N-1:0]         m_cmd,
    input  logic [MASTER_N*AW-1:0]      m_addr,
    input  logic [MASTER_N*DW-1:0]      m_wdata,
    output logic [MASTER_N-1:0]         m_ack,
    output logic [MASTER_N-1:0]         m_resp,
    output logic                        m_err,
    output logic [DW-1:0]               m_rdata,
    output logic                        s_req,
    output logic                        s_cmd,
    output logic [AW-1:0]               s_addr,
    output logic [DW-1:0]               s_wdata,
    input  logic                        s_ack,
    input  logic                        s_resp,
    input  logic [DW-1:0]               s_rdata,
    output logic [$clog2(MASTER_N)-1:0] grant_id,
    output logic                        busy
);

    localparam int IDW = $clog2(MASTER_N);
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT_RESP
    } state_t;

    state_t         state, state_next;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] win;
    logic           found;
    logic [IDW:0]   cand;
    logic [7:0]     cnt;

    // Round-robin pick: scan from ptr upward, wrapping at MASTER_N. One extra
    // bit in cand keeps the sum from overflowing before the wrap compare.
    always_comb begin
        win   = '0;
        found = 1'b0;
        cand  = '0;
        for (int i = 0; i < MASTER_N; i++) begin
            cand = {1'b0, ptr} + (IDW+1)'(i);
            if (cand >= (IDW+1)'(MASTER_N)) begin
                cand = cand - (IDW+1)'(MASTER_N);
            end
            if (!found && m_req[cand[IDW-1:0]]) begin
                found = 1'b1;
                win   = cand[IDW-1:0];
            end
        end
    end

    // Next state and the combinational return path to the owning master.
    always_comb begin
        state_next = state;
        m_ack      = '0;
        m_resp     = '0;
        m_err      = 1'b0;
        m_rdata    = '0;
        case (state)
            IDLE: begin
                if (found) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                // s_resp here is a protocol error and deliberately ignored.
                if (s_ack) begin
                    m_ack[grant_id] = 1'b1;
                    state_next      = s_cmd ? IDLE : WAIT_RESP;
                end
            end
            WAIT_RESP: begin
                if (s_resp) begin
                    m_resp[grant_id] = 1'b1;
                    m_rdata          = s_rdata;
                    state_next       = IDLE;
                end else if (cnt == CNT_LAST) begin
                    // Watchdog expiry: error response so the port never locks.
                    m_resp[grant_id] = 1'b1;
                    m_err            = 1'b1;
                    m_rdata          = '1;
                    state_next       = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            ptr      <= '0;
            grant_id <= '0;
            cnt      <= '0;
            s_cmd    <= 1'b0;
            s_addr   <= '0;
            s_wdata  <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    // The owner's fields are captured once; they are not
                    // re-sampled for the rest of the transaction.
                    if (found) begin
                        grant_id <= win;
                        s_cmd    <= m_cmd[win];
                        s_addr   <= m_addr[int'(win)*AW +: AW];
                        s_wdata  <= m_wdata[int'(win)*DW +: DW];
                        ptr      <= (win == IDW'(MASTER_N - 1)) ? '0 : win + IDW'(1);
                    end
                end
                REQ: begin
                    // Holding the counter at zero here means WAIT_RESP always
                    // starts its count from a clean value.
                    cnt <= '0;
                end
                WAIT_RESP: begin
                    cnt <= cnt + 8'd1;
                end
                default: begin
                end
            endcase
        end
    end

    assign s_req = (state == REQ);
    assign busy  = (state != IDLE);

endmodule

// File: tb/tb_cross_bar_slave_ctrl.sv
// tb_cross_bar_slave_ctrl
// Directed, table-driven bench for cross_bar_slave_ctrl (MASTER_N=4, AW=DW=32,
// TIMEOUT=16). Each table record is one clock cycle: inputs are driven just
// after the rising edge and outputs are compared at the falling edge.
module tb_cross_bar_slave_ctrl;

    localparam int MN = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 16;

    localparam logic [31:0] A0 = 32'h0000_0040, A1 = 32'h0000_0080;
    localparam logic [31:0] A2 = 32'h0000_0100, A3 = 32'h0000_0300;
    localparam logic [31:0] W0 = 32'h1111_1111, W1 = 32'h2222_2222;
    localparam logic [31:0] W2 = 32'hA5A5_A5A5, W3 = 32'h3333_3333;

    logic              clk = 1'b0;
    logic              reset;
    logic [MN-1:0]     m_req;
    logic [MN-1:0]     m_cmd;
    logic [MN*AW-1:0]  m_addr;
    logic [MN*DW-1:0]  m_wdata;
    logic [MN-1:0]     m_ack;
    logic [MN-1:0]     m_resp;
    logic              m_err;
    logic [DW-1:0]     m_rdata;
    logic              s_req;
    logic              s_cmd;
    logic [AW-1:0]     s_addr;
    logic [DW-1:0]     s_wdata;
    logic              s_ack;
    logic              s_resp;
    logic [DW-1:0]     s_rdata;
    logic [1:0]        grant_id;
    logic              busy;

    int checks = 0;
    int errors = 0;

    cross_bar_slave_ctrl #(
        .MASTER_N(MN), .AW(AW), .DW(DW), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .reset(reset),
        .m_req(m_req), .m_cmd(m_cmd), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_ack(m_ack), .m_resp(m_resp), .m_err(m_err), .m_rdata(m_rdata),
        .s_req(s_req), .s_cmd(s_cmd), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_ack(s_ack), .s_resp(s_resp), .s_rdata(s_rdata),
        .grant_id(grant_id), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic [3:0]  cmd;
        logic        sack;
        logic        sresp;
        logic [31:0] srdata;
        logic [3:0]  ack;
        logic [3:0]  resp;
        logic        err;
        logic [31:0] rdata;
        logic        sreq;
        logic        scmd;
        logic [31:0] saddr;
        logic [31:0] swdata;
        logic [1:0]  gid;
        logic        busy;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(
        input logic rst, input logic [3:0] req, input logic [3:0] cmd,
        input logic sack, input logic sresp, input logic [31:0] srdata,
        input logic [3:0] ack, input logic [3:0] resp, input logic err,
        input logic [31:0] rdata, input logic sreq, input logic scmd,
        input logic [31:0] saddr, input logic [31:0] swdata,
        input logic [1:0] gid, input logic bsy);
        vec_t v;
        v.rst = rst; v.req = req; v.cmd = cmd; v.sack = sack; v.sresp = sresp;
        v.srdata = srdata; v.ack = ack; v.resp = resp; v.err = err;
        v.rdata = rdata; v.sreq = sreq; v.scmd = scmd; v.saddr = saddr;
        v.swdata = swdata; v.gid = gid; v.busy = bsy;
        return v;
    endfunction

    task automatic chk(input string nm, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s [%0d]: got %h expected %h", nm, idx, act, exp);
        end
    endtask

    // One clock cycle: drive just after the edge, leave the tb at the falling
    // edge so the caller can compare.
    task automatic drive(input logic rst, input logic [3:0] req, input logic [3:0] cmd,
                         input logic sack, input logic sresp, input logic [31:0] srdata);
        @(posedge clk);
        #1;
        reset   = rst;
        m_req   = req;
        m_cmd   = cmd;
        s_ack   = sack;
        s_resp  = sresp;
        s_rdata = srdata;
        #4;
    endtask

    task automatic check_vec(input int i, input vec_t v);
        chk("m_ack",    i, 32'(m_ack),    32'(v.ack));
        chk("m_resp",   i, 32'(m_resp),   32'(v.resp));
        chk("m_err",    i, 32'(m_err),    32'(v.err));
        chk("m_rdata",  i, m_rdata,       v.rdata);
        chk("s_req",    i, 32'(s_req),    32'(v.sreq));
        chk("s_cmd",    i, 32'(s_cmd),    32'(v.scmd));
        chk("s_addr",   i, s_addr,        v.saddr);
        chk("s_wdata",  i, s_wdata,       v.swdata);
        chk("grant_id", i, 32'(grant_id), 32'(v.gid));
        chk("busy",     i, 32'(busy),     32'(v.busy));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        reset   = 1'b1;
        m_req   = '0;
        m_cmd   = '0;
        m_addr  = {A3, A2, A1, A0};
        m_wdata = {W3, W2, W1, W0};
        s_ack   = 1'b0;
        s_resp  = 1'b0;
        s_rdata = '0;
        repeat (2) @(posedge clk);

        //                rst req      cmd      sa sr srdata        ack      resp     e rdata         sq sc saddr swdata gid bsy
        // Reset state
        vq.push_back(mk(0, 4'b0000, 4'b0000, 0, 0, 32'h0,        4'b0000, 4'b0000, 0, 32'h0,        0, 0, 32'h0, 32'h0, 0, 0));
        // Single write from master 2
        vq.push_back(mk(0, 4'b0100, 4'b0100, 0, 0, 32'h0,        4'b0000, 4'b0000, 0, 32'h0,        0, 0, 32'h0, 32'h0, 0, 0));
        vq.push_back(mk(0, 4'b0100, 4'b0100, 1, 0, 32'h0,        4'b0100, 4'b0000, 0, 32'h0,        1, 1, A2,    W2,    2, 1));
        vq.push_back(mk(0, 4'b0000, 4'b0000, 0, 0, 32'h0,        4'b0000, 4'b0000, 0, 32'h0,        0, 1, A2,    W2,    2, 0));
        // Single read from master 1, response 3 cycles after the ack
        vq.push_back(mk(0, 4'b0010, 4'b0000, 0, 0, 32'h0,        4'b0000, 4'b0000, 0, 32'h0,        0, 1, A2,    W2,    2, 0));
        vq.push_back(mk(0, 4'b0010, 4'b0000, 1, 0, 32'h0,        4'b0010, 4'b0000, 0, 32'h0,        1, 0, A1,    W1,    1, 1));
        vq.push_back(mk(0, 4'b0000, 4'b0000, 0, 0, 32'h0,        4'b0000, 4'b0000, 0, 32'h0,        0, 0, A1,    W1,    1, 1));
        vq.push_back(mk(0, 4'b0000, 4'b0000, 0, 0, 32'h0,        4'b0000, 4'b0000, 0, 32'h0,        0, 0, A1,    W1,    1, 1));
        vq.push_back(mk(0, 4'b0000, 4'b0000, 0, 1, 32'h12345678, 4'b0000, 4'b0010, 0, 32'h12345678, 0, 0, A1,    W1,    1, 1));
        // Stray s_ack / s_resp in IDLE are ignored
        vq.push_back(mk(0, 4'b0000, 4'b0000, 1, 1, 32'hDEADBEEF, 4'b0000, 4'b0000, 0, 32'h0,        0, 0, A1,    W1,    1, 0));
        // Reset, then all four masters request writes continuously
        vq.push_back(mk(1, 4'b0000, 4'b0000, 0, 0, 32'h0,        4'b0000, 4'b0000, 0, 32'h0,        0, 0, A1,    W1,    1, 0));
        vq.push_back(mk(0, 4'b1111, 4'b1111, 0, 0, 32'h0,        4'b0000, 4'b0000, 0, 32'h0,        0, 0, 32'h0, 32'h0, 0, 0));
        vq.push_back(mk(0, 4'b1111, 4'b1111, 1, 0, 32'h0,        4'b0001, 4'b0000, 0, 32'h0,        1, 1, A0,    W0,    0, 1));
        vq.push_back(mk(0, 4'b1111, 4'b1111, 0, 0, 32'h0,        4'b0000, 4'b0000, 0, 32'h0,        0, 1, A0,    W0,    0, 0));
        vq.push_back(mk(0, 4'b1111, 4'b1111, 1, 0, 32'h0,        4'b0010, 4'b0000, 0, 32'h0,        1, 1, A1,    W1,    1, 1));
        vq.push_back(mk(0, 4'b1111, 4'b1111, 0, 0, 32'h0,        4'b0000, 4'b0000, 0, 32'h0,        0, 1, A1,    W1,    1, 0));
        vq.push_back(mk(0, 4'b1111, 4'b1111, 1, 0, 32'h0,        4'b0100, 4'b0000, 0, 32'h0,        1, 1, A2,    W2,    2, 1));
        vq.push_back(mk(0, 4'b1111, 4'b1111, 0, 0, 32'h0,        4'b0000, 4'b0000, 0, 32'h0,        0, 1, A2,    W2,    2, 0));
        vq.push_back(mk(0, 4'b1111, 4'b1111, 1, 0, 32'h0,        4'b1000, 4'b0000, 0, 32'h0,        1, 1, A3,    W3,    3, 1));
        vq.push_back(mk(0, 4'b1111, 4'b1111, 0, 0, 32'h0,        4'b0000, 4'b0000, 0, 32'h0,        0, 1, A3,    W3,    3, 0));
        // REQ stalls without s_ack; s_resp in REQ is ignored
        vq.push_back(mk(0, 4'b1111, 4'b1111, 0, 1, 32'hCAFEF00D, 4'b0000, 4'b0000, 0, 32'h0,        1, 1, A0,    W0,    0, 1));
        vq.push_back(mk(0, 4'b1111, 4'b1111, 1, 0, 32'h0,        4'b0001, 4'b0000, 0, 32'h0,        1, 1, A0,    W0,    0, 1));
        vq.push_back(mk(0, 4'b0000, 4'b0000, 0, 0, 32'h0,        4'b0000, 4'b0000, 0, 32'h0,        0, 1, A0,    W0,    0, 0));
        // Wrap-around: master 3 wins, then 0 and 2 together -> 0 then 2
        vq.push_back(mk(0, 4'b1000, 4'b1000, 0, 0, 32'h0,        4'b0000, 4'b0000, 0, 32'h0,        0, 1, A0,    W0,    0, 0));
        vq.push_back(mk(0, 4'b1000, 4'b1000, 1, 0, 32'h0,        4'b1000, 4'b0000, 0, 32'h0,        1, 1, A3,    W3,    3, 1));
        vq.push_back(mk(0, 4'b0101, 4'b0101, 0, 0, 32'h0,        4'b0000, 4'b0000, 0, 32'h0,        0, 1, A3,    W3,    3, 0));
        vq.push_back(mk(0, 4'b0101, 4'b0101, 1, 0, 32'h0,        4'b0001, 4'b0000, 0, 32'h0,        1, 1, A0,    W0,    0, 1));
        vq.push_back(mk(0, 4'b0101, 4'b0101, 0, 0, 32'h0,        4'b0000, 4'b0000, 0, 32'h0,        0, 1, A0,    W0,    0, 0));
        vq.push_back(mk(0, 4'b0101, 4'b0101, 1, 0, 32'h0,        4'b0100, 4'b0000, 0, 32'h0,        1, 1, A2,    W2,    2, 1));
        vq.push_back(mk(0, 4'b0000, 4'b0000, 0, 0, 32'h0,        4'b0000, 4'b0000, 0, 32'h0,        0, 1, A2,    W2,    2, 0));

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].rst, vq[i].req, vq[i].cmd, vq[i].sack, vq[i].sresp, vq[i].srdata);
            check_vec(i, vq[i]);
        end

        // Timeout: read from master 0 (ptr is 3, so 0 wins on the wrap), no s_resp.
        drive(0, 4'b0001, 4'b0000, 0, 0, 32'h0);
        chk("to_idle_busy", 0, 32'(busy), 32'd0);
        drive(0, 4'b0001, 4'b0000, 1, 0, 32'h0);
        chk("to_ack", 0, 32'(m_ack), 32'h1);
        chk("to_gid", 0, 32'(grant_id), 32'd0);
        for (int k = 0; k < TO; k++) begin
            drive(0, 4'b0000, 4'b0000, 0, 0, 32'h0);
            if (k < TO - 1) begin
                chk("to_wait_resp", k, 32'(m_resp), 32'h0);
                chk("to_wait_busy", k, 32'(busy), 32'd1);
            end else begin
                chk("to_resp", k, 32'(m_resp), 32'h1);
                chk("to_err", k, 32'(m_err), 32'd1);
                chk("to_rdata", k, m_rdata, 32'hFFFF_FFFF);
            end
        end
        // Late s_resp after the timeout produces nothing.
        drive(0, 4'b0000, 4'b0000, 0, 1, 32'h5555_AAAA);
        chk("late_resp", 0, 32'(m_resp), 32'h0);
        chk("late_err", 0, 32'(m_err), 32'd0);
        chk("late_rdata", 0, m_rdata, 32'h0);
        chk("late_busy", 0, 32'(busy), 32'd0);

        // Reset while master 3 owns a read in WAIT_RESP.
        drive(0, 4'b1000, 4'b0000, 0, 0, 32'h0);
        drive(0, 4'b1000, 4'b0000, 1, 0, 32'h0);
        chk("rst_ack", 0, 32'(m_ack), 32'h8);
        chk("rst_gid", 0, 32'(grant_id), 32'd3);
        drive(0, 4'b0000, 4'b0000, 0, 0, 32'h0);
        chk("rst_wait_busy", 0, 32'(busy), 32'd1);
        drive(1, 4'b0000, 4'b0000, 0, 0, 32'h0);
        drive(0, 4'b1010, 4'b1010, 0, 1, 32'h7777_7777);
        chk("rst_busy", 0, 32'(busy), 32'd0);
        chk("rst_sreq", 0, 32'(s_req), 32'd0);
        chk("rst_resp", 0, 32'(m_resp), 32'h0);
        chk("rst_rdata", 0, m_rdata, 32'h0);
        drive(0, 4'b1010, 4'b1010, 1, 0, 32'h0);
        chk("rst_regrant_ack", 0, 32'(m_ack), 32'h2);
        chk("rst_regrant_gid", 0, 32'(grant_id), 32'd1);
        chk("rst_regrant_addr", 0, s_addr, A1);
        drive(0, 4'b0000, 4'b0000, 0, 0, 32'h0);
        chk("end_busy", 0, 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
